// File: rtl/draw_source_arbiter_if.sv
`default_nettype none
// ============================================================================
// draw_source_arbiter_if
//   Shared per-source pixel write bus between the draw manager and the sources.
//   Revision: 1.0
// ============================================================================
interface draw_source_arbiter_if #(
    parameter int SOURCE_SEL_ADDRW  = 3,
    parameter int COLOR_DEPTH       = 9,
    parameter int DRAW_WIDTH_ADDRW  = 8,
    parameter int DRAW_HEIGHT_ADDRW = 7
);
    logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel;
    logic                         write_awaited;
    logic                         write_active;
    logic [COLOR_DEPTH-1:0]       write_color_data;
    logic                         write_transparent;
    logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr;
    logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr;

    // Arbiter side
    modport master (
        output write_source_sel,
        output write_awaited,
        input  write_active,
        input  write_color_data,
        input  write_transparent,
        input  write_x_addr,
        input  write_y_addr
    );

    // Draw-source side
    modport slave (
        input  write_source_sel,
        input  write_awaited,
        output write_active,
        output write_color_data,
        output write_transparent,
        output write_x_addr,
        output write_y_addr
    );
endinterface
`default_nettype wire

// File: rtl/draw_source_arbiter.sv
`default_nettype none
// ============================================================================
// draw_source_arbiter
//   Per-frame optional framebuffer clear, then round-robin grant of each draw
//   source; opaque pixels become linear framebuffer writes.
//   Optional: `define DRAW_ARB_BOUNDS_CHECK_EN drops off-screen pixels and adds
//   the bounds_drop output.
//   Revision: 1.0
// ============================================================================
module draw_source_arbiter #(
    parameter int NUM_SOURCES      = 4,
    parameter int SOURCE_SEL_ADDRW = 3,
    parameter int DRAW_WIDTH       = 160,
    parameter int DRAW_HEIGHT      = 120,
    parameter int COLOR_DEPTH      = 9,
    parameter int WAIT_TIMEOUT     = 4096,
    localparam int DRAW_WIDTH_ADDRW  = $clog2(DRAW_WIDTH),
    localparam int DRAW_HEIGHT_ADDRW = $clog2(DRAW_HEIGHT),
    localparam int FB_ADDRW          = $clog2(DRAW_WIDTH * DRAW_HEIGHT)
) (
    input  wire logic                   clk,
    input  wire logic                   resetN,
    input  wire logic                   frame_start,
    input  wire logic                   clear_en,
    input  wire logic [COLOR_DEPTH-1:0] bg_color,
    draw_source_arbiter_if.master       wr_bus,
    output logic                        fb_we,
    output logic [FB_ADDRW-1:0]         fb_addr,
    output logic [COLOR_DEPTH-1:0]      fb_data,
    output logic                        busy,
    output logic                        frame_done,
    output logic [7:0]                  timeout_count,
    output logic                        frame_overrun
`ifdef DRAW_ARB_BOUNDS_CHECK_EN
    ,
    output logic                        bounds_drop
`endif
);

    localparam int WAIT_CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

    localparam logic [SOURCE_SEL_ADDRW-1:0] c_NO_SOURCE  = '1;
    localparam logic [SOURCE_SEL_ADDRW-1:0] c_LAST_SRC   = SOURCE_SEL_ADDRW'(NUM_SOURCES - 1);
    localparam logic [WAIT_CNT_W-1:0]       c_WAIT_LAST  = WAIT_CNT_W'(WAIT_TIMEOUT - 1);
    localparam logic [FB_ADDRW-1:0]         c_FB_LAST    = FB_ADDRW'(DRAW_WIDTH * DRAW_HEIGHT - 1);
    localparam logic [FB_ADDRW-1:0]         c_DRAW_WIDTH = FB_ADDRW'(DRAW_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_CLEAR       = 3'd1,
        S_SELECT      = 3'd2,
        S_WAIT_ACTIVE = 3'd3,
        S_DRAIN       = 3'd4,
        S_DONE        = 3'd5
    } state_t;

    state_t                         r_state;
    logic [SOURCE_SEL_ADDRW-1:0]    r_index;
    logic [SOURCE_SEL_ADDRW-1:0]    r_sel;
    logic                           r_awaited;
    logic [WAIT_CNT_W-1:0]          r_wait_cnt;
    logic                           r_fb_we;
    logic [FB_ADDRW-1:0]            r_fb_addr;
    logic [COLOR_DEPTH-1:0]         r_fb_data;
    logic                           r_busy;
    logic                           r_frame_done;
    logic [7:0]                     r_timeout_count;
    logic                           r_overrun;

    logic                           w_sampling;
    logic                           w_accept;
    logic                           w_pix_we;
    logic [FB_ADDRW-1:0]            w_pix_addr;
    logic                           w_more_src;
    logic [SOURCE_SEL_ADDRW-1:0]    w_next_index;

    // Bus inputs are only looked at while a source is actually granted, so the
    // floating bus of unselected cycles never reaches the write pipeline.
    assign w_sampling   = (r_state == S_WAIT_ACTIVE) || (r_state == S_DRAIN);
    assign w_accept     = w_sampling && wr_bus.write_active;
    assign w_pix_addr   = FB_ADDRW'(wr_bus.write_y_addr) * c_DRAW_WIDTH
                        + FB_ADDRW'(wr_bus.write_x_addr);
    assign w_more_src   = (r_index < c_LAST_SRC);
    assign w_next_index = r_index + 1'b1;

`ifdef DRAW_ARB_BOUNDS_CHECK_EN
    logic w_oob;
    logic r_bounds_drop;

    assign w_oob    = (32'(wr_bus.write_x_addr) >= 32'(DRAW_WIDTH))
                   || (32'(wr_bus.write_y_addr) >= 32'(DRAW_HEIGHT));
    assign w_pix_we = !wr_bus.write_transparent && !w_oob;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_bounds_drop <= 1'b0;
        end else begin
            r_bounds_drop <= w_accept && w_oob && !wr_bus.write_transparent;
        end
    end

    assign bounds_drop = r_bounds_drop;
`else
    assign w_pix_we = !wr_bus.write_transparent;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state         <= S_IDLE;
            r_index         <= '0;
            r_sel           <= c_NO_SOURCE;
            r_awaited       <= 1'b0;
            r_wait_cnt      <= '0;
            r_fb_we         <= 1'b0;
            r_fb_addr       <= '0;
            r_fb_data       <= '0;
            r_busy          <= 1'b0;
            r_frame_done    <= 1'b0;
            r_timeout_count <= '0;
            r_overrun       <= 1'b0;
        end else begin
            r_fb_we      <= 1'b0;
            r_frame_done <= 1'b0;

            // Accept pipeline runs independently of the state update so the
            // last pixel of a source can still land in the next SELECT cycle.
            if (w_accept) begin
                r_fb_we   <= w_pix_we;
                r_fb_addr <= w_pix_addr;
                r_fb_data <= wr_bus.write_color_data;
            end

            if (frame_start && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_sel     <= c_NO_SOURCE;
                    r_awaited <= 1'b0;
                    if (frame_start) begin
                        r_index <= '0;
                        r_busy  <= 1'b1;
                        if (clear_en) begin
                            r_state   <= S_CLEAR;
                            r_fb_we   <= 1'b1;
                            r_fb_addr <= '0;
                            r_fb_data <= bg_color;
                        end else begin
                            r_state <= S_SELECT;
                            r_sel   <= '0;
                        end
                    end
                end

                // r_fb_data holds the latched background colour for the sweep.
                S_CLEAR: begin
                    if (r_fb_addr == c_FB_LAST) begin
                        r_state <= S_SELECT;
                        r_sel   <= r_index;
                    end else begin
                        r_fb_we   <= 1'b1;
                        r_fb_addr <= r_fb_addr + 1'b1;
                    end
                end

                S_SELECT: begin
                    r_state    <= S_WAIT_ACTIVE;
                    r_awaited  <= 1'b1;
                    r_wait_cnt <= '0;
                end

                S_WAIT_ACTIVE: begin
                    if (wr_bus.write_active) begin
                        r_state   <= S_DRAIN;
                        r_awaited <= 1'b0;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_awaited <= 1'b0;
                        if (r_timeout_count != 8'hFF) begin
                            r_timeout_count <= r_timeout_count + 1'b1;
                        end
                        if (w_more_src) begin
                            r_index <= w_next_index;
                            r_sel   <= w_next_index;
                            r_state <= S_SELECT;
                        end else begin
                            r_sel        <= c_NO_SOURCE;
                            r_frame_done <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (!wr_bus.write_active) begin
                        if (w_more_src) begin
                            r_index <= w_next_index;
                            r_sel   <= w_next_index;
                            r_state <= S_SELECT;
                        end else begin
                            r_sel        <= c_NO_SOURCE;
                            r_frame_done <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_sel   <= c_NO_SOURCE;
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_sel     <= c_NO_SOURCE;
                    r_awaited <= 1'b0;
                end
            endcase
        end
    end

    assign wr_bus.write_source_sel = r_sel;
    assign wr_bus.write_awaited    = r_awaited;
    assign fb_we                   = r_fb_we;
    assign fb_addr                 = r_fb_addr;
    assign fb_data                 = r_fb_data;
    assign busy                    = r_busy;
    assign frame_done              = r_frame_done;
    assign timeout_count           = r_timeout_count;
    assign frame_overrun           = r_overrun;

endmodule
`default_nettype wire
